icache_sa_line: RTL and testbench
=================================

Name: icache_sa_line

Overview:
- Parametrised successor to the direct-mapped halfword I-cache.
- Set-associative, multi-word lines with its own refill FSM. Misses are fetched as whole-line bursts from the Memory Controller.
- Sits between Fetcher and Memory Controller. Serves 16-bit (RVC) and 32-bit instructions, including 32-bit instructions straddling two lines.
- Adds fence.i invalidation.

Parameters:
- SETS, 64, number of sets (power of 2, >=2)
- WAYS, 2, associativity (1 or 2)
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
- XLEN, 32, address/data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- rdy  in  1  global enable; when 0, all state holds
- flush  in  1  pipeline flush from ROB
- stall  in  1  Fetcher stalled
- fence_i  in  1  invalidate all lines
- fet_icache_enable  in  1  Fetcher lookup valid
- fet_pc  in  XLEN  lookup address, halfword aligned
- icache_ready  out  1  instruction valid this cycle (combinational hit)
- icache_inst  out  XLEN  instruction; RVC zero-extended in [31:16]
- icache_mem_req  out  1  refill request, held high until first beat
- icache_mem_addr  out  XLEN  line-aligned refill address
- mem_busy  in  1  controller busy; request not accepted this cycle
- mem_beat_valid  in  1  one refill word returned
- mem_beat_data  in  XLEN  refill word, ascending address order

Behaviour:
- Address split: offset = log2(LINE_WORDS*4) bits; index = log2(SETS) bits; tag = the remaining upper bits.
- Lookup is combinational, same cycle. Halfword h0 is at fet_pc. If h0[1:0]==2'b11, h1 is at fet_pc+2.
- If fet_pc+2 falls in the next line, h1 requires a hit on that line's set/tag. The index wraps from SETS-1 to 0, with tag+1 on wrap.
- icache_ready = enable && hit(h0) && (RVC || hit(h1)). When icache_ready is 0, icache_inst = 0.
- Reset (rst==0 && rdy):
  - all valid bits 0, LRU bits 0
  - FSM IDLE, beat counter 0
  - icache_mem_req 0, icache_mem_addr 0
  - icache_ready 0 while rst is low
- FSM states:
  - IDLE: on enable && !icache_ready && !stall && !flush && !fence_i, latch the miss line address, then go to REQ. The miss line is h0's line if h0 misses, else h1's line. Victim way is chosen now: first invalid way in the set, else the LRU way.
  - REQ: icache_mem_req=1. The request is accepted on the first cycle with !mem_busy. The next state is FILL (beats may begin the cycle after acceptance).
  - FILL: each mem_beat_valid writes mem_beat_data into word[cnt] of the victim and increments cnt. On beat LINE_WORDS-1: write tag, set valid, mark the way MRU, then go to IDLE.
- Latency: h0 miss on a quiet bus = 1 (IDLE->REQ) + 1 (accept) + LINE_WORDS beats + 1 lookup; 7 cycles for LINE_WORDS=4. A straddling 32-bit instruction with both lines missing takes two sequential refills.
- A line is never valid while partially filled. The valid bit is written only on the final beat.
- flush during REQ/FILL: the refill continues to completion and installs, because memory contents are still correct and the controller cannot cancel. Only the Fetcher's request is dropped.
- fence_i: clears all valid bits the same cycle. If it arrives during REQ/FILL, that refill completes its beats but installs with valid=0. fence_i and rst together: reset wins.
- LRU (WAYS=2): one bit per set, updated on icache_ready && !stall (hit way becomes MRU) and on refill install. With WAYS=1 there is no LRU state and the victim is always way 0.
- mem_beat_valid outside FILL is ignored.
- rdy==0 freezes the FSM, counter and arrays. Outputs remain combinational on held state.

Decomposition:
- global_params.v gains ICACHE_SETS, ICACHE_WAYS, ICACHE_LINE_WORDS, and the FSM state encodings ICACHE_IDLE/REQ/FILL.
- One sub-module, icache_way. It holds the valid/tag/data arrays for one way, with two combinational read ports (h0 and h1 set) and one word write port. It is instantiated WAYS times.
- Hit/mux logic, LRU and the FSM stay in the top.

Test Plan:
- Cold miss: fet_pc=0x1000 holding 32-bit 0x00A00093, line words 0x00A00093,0x00000013,... -> icache_mem_addr=0x1000, 4 beats, icache_ready=1 with inst 0x00A00093 in cycle 7; a repeat lookup hits in 0 cycles.
- RVC: word 0x4505_4581 at 0x2000; pc=0x2000 -> inst 0x00004581; pc=0x2002 -> 0x00004505, with no new request.
- Straddle: 32-bit instruction at 0x100E with line 0x1000 cached and 0x1010 not -> refill issued for 0x1010 only; inst assembled from the two halves.
- 2-way conflict: fill 0x0000, then 0x0400 (same set at SETS=64, LINE 16 B), touch 0x0000, then miss 0x0800 -> 0x0400's way replaced; 0x0000 still hits.
- fence_i asserted mid-FILL at beat 2 -> all lookups miss afterwards, refilled line not valid, FSM returns to IDLE after beat 3.
- rst low mid-FILL with beats still arriving -> icache_mem_req=0, FSM IDLE, all misses; the stray beats are ignored.

Source files
------------

// File: rtl/icache_sa_line_pkg.sv
// Shared configuration, FSM encoding and halfword helper for the set-associative I-cache.
package icache_sa_line_pkg;

  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_WAYS       = 2;
  localparam int ICACHE_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_REQ  = 2'd1,
    ICACHE_FILL = 2'd2
  } icache_state_e;

  // Select the upper or lower halfword of a 32-bit word.
  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/icache_sa_line_way.sv
// One way of the I-cache: valid/tag/data arrays, two combinational read ports
// (h0 set and h1 set) and a single word write port used by the refill FSM.
module icache_sa_line_way #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22,
  parameter int XLEN       = 32,
  parameter int IDX_W      = $clog2(SETS),
  parameter int WSEL_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx0,
  input  logic [WSEL_W-1:0] wsel0,
  input  logic [IDX_W-1:0]  idx1,
  input  logic [WSEL_W-1:0] wsel1,
  output logic              valid0,
  output logic [TAG_W-1:0]  tag0,
  output logic [XLEN-1:0]   data0,
  output logic              valid1,
  output logic [TAG_W-1:0]  tag1,
  output logic [XLEN-1:0]   data1,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WSEL_W-1:0] wr_wsel,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              inst_en,
  input  logic [TAG_W-1:0]  inst_tag,
  input  logic              inst_valid
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags  [SETS];
  logic [XLEN-1:0]  words [SETS*LINE_WORDS];

  assign valid0 = valid[idx0];
  assign tag0   = tags[idx0];
  assign data0  = words[{idx0, wsel0}];
  assign valid1 = valid[idx1];
  assign tag1   = tags[idx1];
  assign data1  = words[{idx1, wsel1}];

  // Valid bits: a clear (reset or fence.i) beats a same-cycle install.
  always_ff @(posedge clk) begin
    if (clr)          valid <= '0;
    else if (inst_en) valid[wr_idx] <= inst_valid;
  end

  // Tag and data storage; only control state is cleared, contents are left as-is.
  always_ff @(posedge clk) begin
    if (inst_en) tags[wr_idx] <= inst_tag;
    if (wr_en)   words[{wr_idx, wr_wsel}] <= wr_data;
  end

endmodule

// File: rtl/icache_sa_line.sv
// Set-associative instruction cache with whole-line burst refill. Serves RVC and
// 32-bit instructions (including ones straddling two lines) in the lookup cycle.
module icache_sa_line
  import icache_sa_line_pkg::*;
#(
  parameter int SETS       = ICACHE_SETS,
  parameter int WAYS       = ICACHE_WAYS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            stall,
  input  logic            fence_i,
  input  logic            fet_icache_enable,
  input  logic [XLEN-1:0] fet_pc,
  output logic            icache_ready,
  output logic [XLEN-1:0] icache_inst,
  output logic            icache_mem_req,
  output logic [XLEN-1:0] icache_mem_addr,
  input  logic            mem_busy,
  input  logic            mem_beat_valid,
  input  logic [XLEN-1:0] mem_beat_data
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = XLEN - OFF_W - IDX_W;
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(LINE_WORDS - 1);

  logic [XLEN-1:0]   pc2;
  logic [IDX_W-1:0]  idx0, idx1;
  logic [TAG_W-1:0]  tag0, tag1;
  logic [WSEL_W-1:0] wsel0, wsel1;
  logic              unused_bits;

  logic [WAYS-1:0]   way_v0, way_v1, hit0, hit1, vsel;
  logic [TAG_W-1:0]  way_t0 [WAYS];
  logic [TAG_W-1:0]  way_t1 [WAYS];
  logic [XLEN-1:0]   way_d0 [WAYS];
  logic [XLEN-1:0]   way_d1 [WAYS];
  logic [XLEN-1:0]   word0, word1;
  logic [15:0]       h0, h1;
  logic              rvc, hit0_any, hit1_any, lookup_ok;

  icache_state_e     state, state_n;
  logic [WSEL_W-1:0] cnt;
  logic [IDX_W-1:0]  miss_idx, miss_idx_n;
  logic [TAG_W-1:0]  miss_tag, miss_tag_n;
  logic              victim, victim_n, fence_pend;
  logic              beat, install, way_clr;

  // h1 address; a carry out of the index bits naturally wraps the set and bumps the tag.
  assign pc2   = fet_pc + XLEN'(2);
  assign idx0  = fet_pc[OFF_W +: IDX_W];
  assign tag0  = fet_pc[OFF_W + IDX_W +: TAG_W];
  assign wsel0 = fet_pc[2 +: WSEL_W];
  assign idx1  = pc2[OFF_W +: IDX_W];
  assign tag1  = pc2[OFF_W + IDX_W +: TAG_W];
  assign wsel1 = pc2[2 +: WSEL_W];
  assign unused_bits = fet_pc[0] ^ pc2[0];

  assign beat    = rdy && rst && (state == ICACHE_FILL) && mem_beat_valid;
  assign install = beat && (cnt == LAST_BEAT);
  assign way_clr = rdy && (!rst || fence_i);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic sel;
    assign sel = (victim == 1'(w));

    icache_sa_line_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .XLEN(XLEN)
    ) u_way (
      .clk(clk), .clr(way_clr),
      .idx0(idx0), .wsel0(wsel0), .idx1(idx1), .wsel1(wsel1),
      .valid0(way_v0[w]), .tag0(way_t0[w]), .data0(way_d0[w]),
      .valid1(way_v1[w]), .tag1(way_t1[w]), .data1(way_d1[w]),
      .wr_en(beat && sel), .wr_idx(miss_idx), .wr_wsel(cnt), .wr_data(mem_beat_data),
      .inst_en(install && sel), .inst_tag(miss_tag),
      .inst_valid(!(fence_pend || fence_i))
    );

    assign hit0[w] = way_v0[w] && (way_t0[w] == tag0);
    assign hit1[w] = way_v1[w] && (way_t1[w] == tag1);
  end

  // Select the hitting way's word for each halfword.
  always_comb begin
    word0 = '0;
    word1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit0[w]) word0 = way_d0[w];
      if (hit1[w]) word1 = way_d1[w];
    end
  end

  assign hit0_any  = |hit0;
  assign hit1_any  = |hit1;
  assign h0        = pick_half(word0, fet_pc[1]);
  assign h1        = pick_half(word1, pc2[1]);
  assign rvc       = (h0[1:0] != 2'b11);
  assign lookup_ok = fet_icache_enable && hit0_any && (rvc || hit1_any);

  assign icache_ready    = rst && lookup_ok;
  assign icache_inst     = !icache_ready ? '0 :
                           rvc ? XLEN'({16'h0000, h0}) : XLEN'({h1, h0});
  assign icache_mem_addr = {miss_tag, miss_idx, {OFF_W{1'b0}}};

  // The line to fetch is h0's when h0 misses, otherwise h1's (straddle case).
  assign miss_idx_n = hit0_any ? idx1 : idx0;
  assign miss_tag_n = hit0_any ? tag1 : tag0;
  assign vsel       = hit0_any ? way_v1 : way_v0;

  if (WAYS == 2) begin : g_lru
    // One bit per set naming the least recently used way.
    logic [SETS-1:0] lru;

    assign victim_n = !vsel[0] ? 1'b0 : (!vsel[1] ? 1'b1 : lru[miss_idx_n]);

    // Hits make their way MRU; an install makes the filled way MRU.
    always_ff @(posedge clk) begin
      if (rdy) begin
        if (!rst) begin
          lru <= '0;
        end else begin
          if (icache_ready && !stall) begin
            lru[idx0] <= ~hit0[1];
            if (!rvc) lru[idx1] <= ~hit1[1];
          end
          if (install) lru[miss_idx] <= ~victim;
        end
      end
    end
  end else begin : g_nolru
    assign victim_n = 1'b0;
  end

  // Refill FSM next-state and request output.
  always_comb begin
    state_n        = state;
    icache_mem_req = 1'b0;
    unique case (state)
      ICACHE_IDLE: begin
        if (fet_icache_enable && !icache_ready && !stall && !flush && !fence_i)
          state_n = ICACHE_REQ;
      end
      ICACHE_REQ: begin
        icache_mem_req = 1'b1;
        if (!mem_busy) state_n = ICACHE_FILL;
      end
      ICACHE_FILL: begin
        if (mem_beat_valid && (cnt == LAST_BEAT)) state_n = ICACHE_IDLE;
      end
      default: state_n = ICACHE_IDLE;
    endcase
  end

  // FSM state, miss line/victim capture, beat counter and pending-fence flag.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!rst) begin
        state      <= ICACHE_IDLE;
        cnt        <= '0;
        miss_idx   <= '0;
        miss_tag   <= '0;
        victim     <= 1'b0;
        fence_pend <= 1'b0;
      end else begin
        state <= state_n;
        if ((state == ICACHE_IDLE) && (state_n == ICACHE_REQ)) begin
          miss_idx <= miss_idx_n;
          miss_tag <= miss_tag_n;
          victim   <= victim_n;
        end
        if (beat) cnt <= cnt + WSEL_W'(1);
        if (install)                             fence_pend <= 1'b0;
        else if (fence_i && (state != ICACHE_IDLE)) fence_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_sa_line.sv
// Bench for icache_sa_line: a bench-side memory model serves refill bursts,
// expected refill addresses go through a scoreboard queue, and lookups are
// checked from a vector table plus hand-written multi-cycle sequences.
module tb_icache_sa_line;

  localparam int LW = 4;

  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush = 1'b0, stall = 1'b0, fence_i = 1'b0;
  logic        en = 1'b0, mem_busy = 1'b0, mem_beat_valid = 1'b0;
  logic [31:0] pc = '0, mem_beat_data = '0;
  logic        icache_ready, icache_mem_req;
  logic [31:0] icache_inst, icache_mem_addr;

  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  logic [31:0] exp_q [$];
  logic [31:0] base;

  typedef struct {
    int          phase;
    logic [31:0] pc;
    logic        stall;
    logic        exp_ready;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vt [$];

  icache_sa_line dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall), .fence_i(fence_i),
    .fet_icache_enable(en), .fet_pc(pc),
    .icache_ready(icache_ready), .icache_inst(icache_inst),
    .icache_mem_req(icache_mem_req), .icache_mem_addr(icache_mem_addr),
    .mem_busy(mem_busy), .mem_beat_valid(mem_beat_valid), .mem_beat_data(mem_beat_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1000: return 32'h00A00093;
      32'h1004: return 32'h00000013;
      32'h100C: return 32'h00930001;
      32'h1010: return 32'h123400A0;
      32'h2000: return 32'h45054581;
      default:  return {a[15:0] ^ 16'h5A5A, a[15:2], 2'b01};
    endcase
  endfunction

  // Instruction as fetched from flat memory at byte address a.
  function automatic logic [31:0] model_inst(input logic [31:0] a);
    logic [31:0] w0, w1, a2;
    logic [15:0] h0, h1;
    w0 = mem_word({a[31:2], 2'b00});
    h0 = a[1] ? w0[31:16] : w0[15:0];
    if (h0[1:0] != 2'b11) return {16'h0000, h0};
    a2 = a + 32'd2;
    w1 = mem_word({a2[31:2], 2'b00});
    h1 = a2[1] ? w1[31:16] : w1[15:0];
    return {h1, h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic look(input logic [31:0] a, input logic s);
    pc = a; stall = s; en = 1'b1;
    #1;
  endtask

  // Wait for a request, check it against the scoreboard, then return the line.
  task automatic serve(input int busy_n, input int gap, input int fence_beat);
    int t;
    logic [31:0] b;
    t = 0;
    while (!icache_mem_req && t < 20) begin step(); t++; end
    chk("refill_request_seen", 32'(icache_mem_req), 32'd1);
    if (!icache_mem_req) return;
    if (exp_q.size() == 0) begin
      chk("refill_unexpected", icache_mem_addr, 32'hFFFF_FFFF);
      b = icache_mem_addr;
    end else begin
      b = exp_q.pop_front();
      chk("refill_addr", icache_mem_addr, b);
    end
    mem_busy = (busy_n > 0);
    repeat (busy_n) step();
    if (busy_n > 0) chk("req_held_while_busy", 32'(icache_mem_req), 32'd1);
    mem_busy = 1'b0;
    step();
    for (int k = 0; k < LW; k++) begin
      repeat (gap) step();
      mem_beat_valid = 1'b1;
      mem_beat_data  = mem_word(b + 32'(4 * k));
      fence_i        = (k == fence_beat);
      step();
      mem_beat_valid = 1'b0;
      fence_i        = 1'b0;
    end
    #1;
  endtask

  task automatic run_vecs(input int ph);
    foreach (vt[i]) begin
      if (vt[i].phase == ph) begin
        look(vt[i].pc, vt[i].stall);
        chk($sformatf("vec%0d_%0d_ready", ph, i), 32'(icache_ready), 32'(vt[i].exp_ready));
        chk($sformatf("vec%0d_%0d_inst", ph, i), icache_inst, vt[i].exp_inst);
        step();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt.push_back('{0, 32'h2000, 1'b0, 1'b1, 32'h00004581});
    vt.push_back('{0, 32'h2002, 1'b0, 1'b1, 32'h00004505});
    vt.push_back('{0, 32'h1000, 1'b0, 1'b1, 32'h00A00093});
    vt.push_back('{0, 32'h1004, 1'b0, 1'b1, 32'h00000013});
    vt.push_back('{0, 32'h200C, 1'b0, 1'b1, model_inst(32'h200C)});
    vt.push_back('{0, 32'h5000, 1'b1, 1'b0, 32'h0});
    vt.push_back('{1, 32'h0020, 1'b1, 1'b1, model_inst(32'h0020)});
    vt.push_back('{1, 32'h0420, 1'b1, 1'b0, 32'h0});
    vt.push_back('{1, 32'h0820, 1'b1, 1'b1, model_inst(32'h0820)});
    vt.push_back('{2, 32'h3000, 1'b1, 1'b0, 32'h0});
    vt.push_back('{2, 32'h1000, 1'b1, 1'b0, 32'h0});
    vt.push_back('{2, 32'h0020, 1'b1, 1'b0, 32'h0});
    vt.push_back('{2, 32'h1010, 1'b1, 1'b0, 32'h0});

    // Reset with a lookup pending.
    rst = 1'b0; en = 1'b1; pc = 32'h1000;
    repeat (2) step();
    chk("reset_ready", 32'(icache_ready), 32'd0);
    chk("reset_req", 32'(icache_mem_req), 32'd0);
    chk("reset_addr", icache_mem_addr, 32'd0);
    rst = 1'b1;

    // Cold miss on a 32-bit instruction.
    look(32'h1000, 1'b0);
    t0 = cyc;
    chk("cold_first_cycle_ready", 32'(icache_ready), 32'd0);
    exp_q.push_back(32'h1000);
    serve(0, 0, -1);
    chk("cold_ready", 32'(icache_ready), 32'd1);
    chk("cold_inst", icache_inst, 32'h00A00093);
    chk("cold_latency", 32'(cyc - t0), 32'(1 + 1 + LW));
    step();
    chk("repeat_hit_ready", 32'(icache_ready), 32'd1);
    chk("repeat_hit_req", 32'(icache_mem_req), 32'd0);

    // RVC line, refilled with a busy controller and gaps between beats.
    look(32'h2000, 1'b0);
    exp_q.push_back(32'h2000);
    serve(2, 1, -1);
    run_vecs(0);
    chk("rvc_no_new_request", 32'(icache_mem_req), 32'd0);

    // Straddling 32-bit instruction: only the second line is fetched.
    look(32'h100E, 1'b0);
    chk("straddle_miss", 32'(icache_ready), 32'd0);
    exp_q.push_back(32'h1010);
    serve(0, 0, -1);
    chk("straddle_ready", 32'(icache_ready), 32'd1);
    chk("straddle_inst", icache_inst, 32'h00A00093);
    step();
    chk("straddle_single_refill", 32'(icache_mem_req), 32'd0);

    // Two-way conflict in one set with LRU replacement.
    look(32'h0020, 1'b0); exp_q.push_back(32'h0020); serve(0, 0, -1);
    chk("conf_a_inst", icache_inst, model_inst(32'h0020));
    look(32'h0420, 1'b0); exp_q.push_back(32'h0420); serve(0, 0, -1);
    chk("conf_b_inst", icache_inst, model_inst(32'h0420));
    look(32'h0020, 1'b0);
    chk("conf_touch_a", 32'(icache_ready), 32'd1);
    step();
    look(32'h0820, 1'b0); exp_q.push_back(32'h0820); serve(0, 0, -1);
    chk("conf_c_inst", icache_inst, model_inst(32'h0820));
    run_vecs(1);

    // fence.i arriving on beat 2 of a refill.
    look(32'h3000, 1'b0); exp_q.push_back(32'h3000); serve(0, 0, 2);
    look(32'h3000, 1'b1);
    chk("fence_line_not_valid", 32'(icache_ready), 32'd0);
    run_vecs(2);
    chk("fence_no_request", 32'(icache_mem_req), 32'd0);
    look(32'h3000, 1'b0); exp_q.push_back(32'h3000); serve(0, 0, -1);
    chk("fence_refill_ready", 32'(icache_ready), 32'd1);
    chk("fence_refill_inst", icache_inst, model_inst(32'h3000));

    // Reset in the middle of a refill, with stray beats afterwards.
    look(32'h4000, 1'b0);
    step();
    chk("rst_seq_req", 32'(icache_mem_req), 32'd1);
    base = exp_q.size() == 0 ? 32'h4000 : exp_q.pop_front();
    chk("rst_seq_addr", icache_mem_addr, 32'h4000);
    rdy = 1'b0;
    repeat (2) step();
    chk("rdy_freeze_req", 32'(icache_mem_req), 32'd1);
    rdy = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      mem_beat_valid = 1'b1; mem_beat_data = mem_word(32'h4000 + 32'(4 * k));
      step();
    end
    rst = 1'b0;
    mem_beat_data = mem_word(32'h4008);
    look(32'h3000, 1'b0);
    chk("rst_low_ready", 32'(icache_ready), 32'd0);
    step();
    rst = 1'b1; stall = 1'b1;
    #1;
    chk("rst_req_cleared", 32'(icache_mem_req), 32'd0);
    chk("rst_addr_cleared", icache_mem_addr, 32'd0);
    mem_beat_data = mem_word(32'h400C);
    step();
    mem_beat_data = 32'hDEAD_BEEF;
    step();
    mem_beat_valid = 1'b0;
    look(32'h4000, 1'b1);
    chk("rst_stray_ignored", 32'(icache_ready), 32'd0);
    look(32'h3000, 1'b1);
    chk("rst_all_miss", 32'(icache_ready), 32'd0);
    step();
    chk("rst_idle_no_req", 32'(icache_mem_req), 32'd0);
    look(32'h4000, 1'b0); exp_q.push_back(32'h4000); serve(1, 0, -1);
    chk("rst_refill_ready", 32'(icache_ready), 32'd1);
    chk("rst_refill_inst", icache_inst, model_inst(32'h4000));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
